// File: rtl/stream_nto1_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module : stream_nto1_mux_pkg
//  Brief  : Shared selection-mode encodings for the N-to-1 stream mux.
//  Rev    : 1.0  initial release
// ============================================================================
package stream_nto1_mux_pkg;

  // Selection mode encodings (value of the 'mode' input)
  localparam logic MODE_FIXED = 1'b0;  // channel chosen by 'sel'
  localparam logic MODE_RR    = 1'b1;  // fair round-robin among valid channels

endpackage
`default_nettype wire

// File: rtl/stream_nto1_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Combinational round-robin arbiter. Grants the first requester
//           found scanning ptr+1, ptr+2, ... (mod N). One-hot grant output.
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  // Channel index visited at scan step k, starting just after the pointer
  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % N;
  endfunction

  // Scan from ptr+1 around the ring; first requester wins
  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[wrap_idx(int'(ptr), k)]) begin
        gnt[wrap_idx(int'(ptr), k)] = 1'b1;
        gidx                        = SELW'(wrap_idx(int'(ptr), k));
        any                         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_nto1_mux.sv
`default_nettype none
// ============================================================================
//  Module : stream_nto1_mux
//  Brief  : Registered, valid/ready handshaked N-to-1 stream multiplexer with
//           fixed (sel) or round-robin channel selection.
//  Rev    : 1.0  initial release
// ============================================================================
module stream_nto1_mux
  import stream_nto1_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     w_req;
  logic [N-1:0]     w_gnt;
  logic [SELW-1:0]  w_gidx;
  logic             w_any;
  logic             w_load_en;
  logic [WIDTH-1:0] w_sel_data;

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  // Request vector: all valids in RR, only the selected channel in fixed
  // mode. An out-of-range sel matches no channel and so requests nothing.
  always_comb begin
    w_req = '0;
    if (mode == MODE_RR) begin
      w_req = in_valid;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (SELW'(i) == sel) w_req[i] = in_valid[i];
      end
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req  (w_req),
    .ptr  (r_rr_ptr),
    .gnt  (w_gnt),
    .gidx (w_gidx),
    .any  (w_any)
  );

  // The output register can take a new word when empty or being drained
  assign w_load_en = !r_out_valid | out_ready;
  assign in_ready  = w_load_en ? w_gnt : '0;

  // AND-OR data mux driven by the one-hot grant
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer; pointer moves only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= SELW'(N - 1);
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_gidx;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= w_gidx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire
